// File: rtl/servo_360_sequenciador_pkg.sv
// Shared definitions for the 360-degree servo sequencer: state codes,
// default timing values and a small helper used to size the shared timer.
package servo_pkg;

    localparam int ESTADO_W = 3;

    // Default timing at 50 MHz: 1 s settle, 3 s maximum wait for the servo.
    localparam int PAUSA_CICLOS_PADRAO   = 50_000_000;
    localparam int TIMEOUT_CICLOS_PADRAO = 150_000_000;

    // State codes are visible on db_estado, so they are fixed explicitly.
    typedef enum logic [ESTADO_W-1:0] {
        INICIAL = 3'd0,
        PREPARA = 3'd1,
        DISPARA = 3'd2,
        ESPERA  = 3'd3,
        PAUSA   = 3'd4,
        FINAL   = 3'd5,
        ERRO    = 3'd7
    } estado_t;

    // Larger of two cycle counts; the single timer must cover both uses.
    function automatic int maior(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/servo_360_sequenciador_if.sv
// Signal bundle between the cube-solving controller, the sequencer and the
// servo stage. Handshake: every strobe (iniciar, servo_iniciar, servo_pronto,
// pronto) is a single-cycle pulse sampled on the rising clock edge; iniciar is
// only honoured while the sequencer is idle (ocupado=0, db_estado=0) and there
// is no back-pressure or queuing -- a strobe that arrives while busy is lost.
// The master drives the command and the servo done pulse; the slave is the
// sequencer itself.
interface servo_360_sequenciador_if;

    logic       iniciar;
    logic [1:0] quartos;
    logic       servo_pronto;
    logic       servo_iniciar;
    logic       ocupado;
    logic       pronto;
    logic       erro;
    logic [1:0] db_restantes;
    logic [2:0] db_estado;

    modport master (
        output iniciar,
        output quartos,
        output servo_pronto,
        input  servo_iniciar,
        input  ocupado,
        input  pronto,
        input  erro,
        input  db_restantes,
        input  db_estado
    );

    modport slave (
        input  iniciar,
        input  quartos,
        input  servo_pronto,
        output servo_iniciar,
        output ocupado,
        output pronto,
        output erro,
        output db_restantes,
        output db_estado
    );

endinterface

// File: rtl/servo_360_sequenciador_contador_m.sv
// contador_m: saturating mod-M cycle counter with synchronous clear (zera),
// count enable (conta) and a terminal flag (fim) raised at M-1. It holds at
// M-1 instead of wrapping so a late clear can never look like a fresh count.
module contador_m #(
    parameter int M = 16,
    parameter int W = (M > 1) ? $clog2(M) : 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_zera,
    input  logic         i_conta,
    output logic [W-1:0] o_q,
    output logic         o_fim
);

    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    logic [W-1:0] r_q;

    // Count register: reset/clear to zero, otherwise count up and hold at M-1.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_q <= '0;
        end else if (i_zera) begin
            r_q <= '0;
        end else if (i_conta && (r_q != ULTIMO)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign o_q   = r_q;
    assign o_fim = (r_q == ULTIMO);

endmodule

// File: rtl/servo_360_sequenciador.sv
// servo_360_sequenciador: issues one servo start pulse per requested quarter
// turn (0..3), waits for the servo done pulse after each, inserts a settle
// pause between turns and reports completion upstream.
// Optional feature macro: SEQ_TIMEOUT_EN -- when defined, the wait for the
// servo done pulse is bounded and expiry parks the sequencer in ERRO with a
// sticky erro flag until reset. Default build: unbounded wait, erro tied 0.
module servo_360_sequenciador
    import servo_pkg::*;
#(
    parameter int PAUSA_CICLOS   = PAUSA_CICLOS_PADRAO,
    parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
    input  logic                      clock,
    input  logic                      reset,
    servo_360_sequenciador_if.slave   s
);

    localparam int TEMPO_MAX = maior(PAUSA_CICLOS, TIMEOUT_CICLOS);
    localparam int TW        = (TEMPO_MAX > 1) ? $clog2(TEMPO_MAX) : 1;

    localparam logic [TW-1:0] PAUSA_FIM = TW'(PAUSA_CICLOS - 1);
`ifdef SEQ_TIMEOUT_EN
    localparam logic [TW-1:0] TIMEOUT_FIM = TW'(TIMEOUT_CICLOS - 1);
`endif

    // ---------------- datapath (FD): restantes register + shared timer ----
    estado_t     r_estado;
    logic [1:0]  r_restantes;
    logic        r_servo_iniciar;
    logic        r_pronto;
    logic        r_ocupado;
`ifdef SEQ_TIMEOUT_EN
    logic        r_erro;
    logic        w_tempo_esgotado;
`endif

    logic          w_zera;
    logic          w_conta;
    logic [TW-1:0] w_tempo;
    logic          w_fim;
    logic          w_pausa_fim;

    contador_m #(
        .M (TEMPO_MAX),
        .W (TW)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .i_zera  (w_zera),
        .i_conta (w_conta),
        .o_q     (w_tempo),
        .o_fim   (w_fim)
    );

    // Timer control: cleared whenever a new interval starts, counting only
    // during the settle pause (and, with the timeout build, while waiting).
    always_comb begin
        w_zera  = 1'b0;
        w_conta = 1'b0;
        case (r_estado)
            INICIAL, DISPARA, FINAL: w_zera = 1'b1;
            ESPERA: begin
`ifdef SEQ_TIMEOUT_EN
                if (s.servo_pronto) w_zera = 1'b1;
                else                w_conta = 1'b1;
`else
                if (s.servo_pronto) w_zera = 1'b1;
`endif
            end
            PAUSA:   w_conta = 1'b1;
            default: ;
        endcase
    end

    // A saturated timer also ends the interval, so the FSM cannot stall.
    assign w_pausa_fim = (w_tempo == PAUSA_FIM) || w_fim;
`ifdef SEQ_TIMEOUT_EN
    assign w_tempo_esgotado = (w_tempo == TIMEOUT_FIM) || w_fim;
`endif

    // ---------------- control (UC): state machine with registered outputs --
    // Outputs are assigned together with the state they belong to, so they
    // change on the same edge as db_estado and never depend on live inputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_estado        <= INICIAL;
            r_restantes     <= 2'd0;
            r_servo_iniciar <= 1'b0;
            r_pronto        <= 1'b0;
            r_ocupado       <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            r_erro          <= 1'b0;
`endif
        end else begin
            r_servo_iniciar <= 1'b0;
            r_pronto        <= 1'b0;
            case (r_estado)
                INICIAL: begin
                    if (s.iniciar) begin
                        r_restantes <= s.quartos;
                        r_estado    <= PREPARA;
                        r_ocupado   <= 1'b1;
                    end
                end
                PREPARA: begin
                    if (r_restantes == 2'd0) begin
                        r_estado  <= FINAL;
                        r_pronto  <= 1'b1;
                        r_ocupado <= 1'b0;
                    end else begin
                        r_estado        <= DISPARA;
                        r_servo_iniciar <= 1'b1;
                    end
                end
                DISPARA: begin
                    if (r_restantes != 2'd0) r_restantes <= r_restantes - 2'd1;
                    r_estado <= ESPERA;
                end
                ESPERA: begin
                    if (s.servo_pronto) begin
                        if (r_restantes != 2'd0) begin
                            r_estado <= PAUSA;
                        end else begin
                            r_estado  <= FINAL;
                            r_pronto  <= 1'b1;
                            r_ocupado <= 1'b0;
                        end
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (w_tempo_esgotado) begin
                        r_estado  <= ERRO;
                        r_erro    <= 1'b1;
                        r_ocupado <= 1'b0;
                    end
`endif
                end
                PAUSA: begin
                    if (w_pausa_fim) begin
                        r_estado        <= DISPARA;
                        r_servo_iniciar <= 1'b1;
                    end
                end
                FINAL: begin
                    r_estado <= INICIAL;
                end
                ERRO: begin
                    r_estado  <= ERRO;
                    r_ocupado <= 1'b0;
                end
                default: begin
                    r_estado  <= INICIAL;
                    r_ocupado <= 1'b0;
                end
            endcase
        end
    end

    assign s.servo_iniciar = r_servo_iniciar;
    assign s.ocupado       = r_ocupado;
    assign s.pronto        = r_pronto;
    assign s.db_restantes  = r_restantes;
    assign s.db_estado     = r_estado;
`ifdef SEQ_TIMEOUT_EN
    assign s.erro          = r_erro;
`else
    assign s.erro          = 1'b0;
`endif

endmodule

// File: tb/tb_servo_360_sequenciador.sv
// Directed bench for servo_360_sequenciador with short timing
// (PAUSA_CICLOS=4, TIMEOUT_CICLOS=10). Cycle numbering inside a command:
// cycle 0 is the cycle in which iniciar is driven; cycle k is the cycle
// observed just after the k-th following rising edge.
module tb_servo_360_sequenciador;

    localparam int PAUSA   = 4;
    localparam int TIMEOUT = 10;
    localparam int JANELA  = 40;

    typedef struct {
        logic [1:0] quartos;
        int         atraso;        // cycles from servo_iniciar to servo_pronto
        int         extra_at;      // cycle of a stray iniciar (quartos=3), -1 none
        int         exp_pulsos;
        int         exp_t_pronto;
        int         exp_ocup;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];

    servo_360_sequenciador_if bus ();

    servo_360_sequenciador #(
        .PAUSA_CICLOS   (PAUSA),
        .TIMEOUT_CICLOS (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .s     (bus)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver / check tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
        end
    endtask

    task automatic run_cmd(input vec_t v);
        int t;
        int pulsos;
        int prontos;
        int t_pronto;
        int ocup;
        int sp_at;
        int rem;
        bit chk_rest;
        logic [31:0] e;
        exp_q.delete();
        pulsos   = 0;
        prontos  = 0;
        t_pronto = -1;
        ocup     = 0;
        sp_at    = -1;
        rem      = int'(v.quartos);
        chk_rest = 1'b0;
        if (rem > 0) exp_q.push_back(32'd2);
        bus.quartos = v.quartos;
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        t = 1;
        while (t < JANELA) begin
            bus.servo_pronto = 1'b0;
            if (chk_rest) begin
                check("restantes", 32'(bus.db_restantes), 32'(rem));
                chk_rest = 1'b0;
            end
            if (bus.ocupado) ocup++;
            if (bus.servo_iniciar) begin
                pulsos++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("inicio_ciclo", 32'(t), e);
                end
                if (rem > 0) rem--;
                chk_rest = 1'b1;
                sp_at = t + v.atraso;
            end
            if (t == sp_at) begin
                bus.servo_pronto = 1'b1;
                if (rem > 0) exp_q.push_back(32'(t + PAUSA + 1));
            end
            if (t == v.extra_at) begin
                bus.iniciar = 1'b1;
                bus.quartos = 2'd3;
            end else begin
                bus.iniciar = 1'b0;
            end
            if (bus.pronto) begin
                prontos++;
                if (t_pronto < 0) t_pronto = t;
            end
            tick();
            t++;
        end
        bus.servo_pronto = 1'b0;
        check("pulsos", 32'(pulsos), 32'(v.exp_pulsos));
        check("prontos", 32'(prontos), 32'd1);
        check("t_pronto", 32'(t_pronto), 32'(v.exp_t_pronto));
        check("ocupado_ciclos", 32'(ocup), 32'(v.exp_ocup));
        check("fila_vazia", 32'(exp_q.size()), 32'd0);
        check("estado_final", 32'(bus.db_estado), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t vecs[5];
        int   ruins;
        int   pr_cnt;
        int   si_cnt;

        // quartos, atraso, extra_at, pulses, pronto cycle, ocupado cycles
        vecs[0] = '{quartos: 2'd1, atraso: 5, extra_at: -1, exp_pulsos: 1, exp_t_pronto: 8,  exp_ocup: 7};
        vecs[1] = '{quartos: 2'd3, atraso: 3, extra_at: -1, exp_pulsos: 3, exp_t_pronto: 22, exp_ocup: 21};
        vecs[2] = '{quartos: 2'd0, atraso: 1, extra_at: -1, exp_pulsos: 0, exp_t_pronto: 2,  exp_ocup: 1};
        vecs[3] = '{quartos: 2'd2, atraso: 1, extra_at: -1, exp_pulsos: 2, exp_t_pronto: 10, exp_ocup: 9};
        vecs[4] = '{quartos: 2'd1, atraso: 5, extra_at: 4,  exp_pulsos: 1, exp_t_pronto: 8,  exp_ocup: 7};

        bus.iniciar      = 1'b0;
        bus.quartos      = 2'd0;
        bus.servo_pronto = 1'b0;
        reset            = 1'b0;
        repeat (3) tick();

        check("rst_estado", 32'(bus.db_estado), 32'd0);
        check("rst_servo_iniciar", 32'(bus.servo_iniciar), 32'd0);
        check("rst_ocupado", 32'(bus.ocupado), 32'd0);
        check("rst_pronto", 32'(bus.pronto), 32'd0);
        check("rst_erro", 32'(bus.erro), 32'd0);
        check("rst_restantes", 32'(bus.db_restantes), 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_cmd(vecs[i]);
        end

        // Reset in the middle of the first wait, with servo_pronto arriving.
        bus.quartos = 2'd2;
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        tick();
        check("mr_disparo", 32'(bus.servo_iniciar), 32'd1);
        tick();
        tick();
        check("mr_espera", 32'(bus.db_estado), 32'd3);
        reset            = 1'b0;
        bus.servo_pronto = 1'b1;
        tick();
        reset = 1'b1;
        check("mr_estado", 32'(bus.db_estado), 32'd0);
        check("mr_ocupado", 32'(bus.ocupado), 32'd0);
        check("mr_restantes", 32'(bus.db_restantes), 32'd0);
        check("mr_servo_iniciar", 32'(bus.servo_iniciar), 32'd0);
        tick();
        bus.servo_pronto = 1'b0;
        pr_cnt = 0;
        si_cnt = 0;
        repeat (12) begin
            if (bus.pronto) pr_cnt++;
            if (bus.servo_iniciar) si_cnt++;
            tick();
        end
        check("mr_sem_pronto", 32'(pr_cnt), 32'd0);
        check("mr_sem_disparo", 32'(si_cnt), 32'd0);
        run_cmd(vecs[3]);

        // Servo never answers.
        bus.quartos = 2'd1;
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        repeat (11) tick();
        check("to_espera", 32'(bus.db_estado), 32'd3);
        tick();
`ifdef SEQ_TIMEOUT_EN
        check("to_estado", 32'(bus.db_estado), 32'd7);
        check("to_erro", 32'(bus.erro), 32'd1);
        check("to_ocupado", 32'(bus.ocupado), 32'd0);
        bus.iniciar = 1'b1;
        tick();
        bus.iniciar = 1'b0;
        ruins = 0;
        repeat (20) begin
            if (bus.erro !== 1'b1 || bus.pronto !== 1'b0 || bus.db_estado !== 3'd7) ruins++;
            tick();
        end
        check("to_erro_mantido", 32'(ruins), 32'd0);
`else
        ruins = 0;
        repeat (200) begin
            if (bus.db_estado !== 3'd3 || bus.erro !== 1'b0 || bus.pronto !== 1'b0) ruins++;
            tick();
        end
        check("espera_infinita", 32'(ruins), 32'd0);
`endif
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("rec_estado", 32'(bus.db_estado), 32'd0);
        check("rec_erro", 32'(bus.erro), 32'd0);
        run_cmd(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
